// File: rtl/gol_gen_scheduler_if.sv
// Control/status bundle between the Game of Life front panel and the
// generation scheduler.
interface gol_gen_scheduler_if;
  logic        run;
  logic [3:0]  speed;
  logic        step_btn;
  logic        seed_req;
  logic        vblank_start;
  logic        gen_en;
  logic        seed_en;
  logic        busy;
  logic        overrun;
  logic [15:0] gen_count;

  modport master (
    output run, speed, step_btn, seed_req, vblank_start,
    input  gen_en, seed_en, busy, overrun, gen_count
  );

  modport slave (
    input  run, speed, step_btn, seed_req, vblank_start,
    output gen_en, seed_en, busy, overrun, gen_count
  );
endinterface

// File: rtl/gol_gen_scheduler.sv
// Generation scheduler for the Game of Life cell array. Merges a free-running
// speed timer and a debounced single-step button into one pending request,
// and releases it as a one-cycle gen_en (aligned to vblank when FRAME_SYNC=1)
// or a one-cycle seed_en on a seed request.
module gol_gen_scheduler #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned DB_CYCLES  = 500000,
  parameter bit          FRAME_SYNC = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset,
  gol_gen_scheduler_if.slave  bus
);

  localparam int unsigned DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VBL,
    ISSUE,
    SEED,
    HOLD
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] base_period;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] tmr_cnt;
  logic             timer_tick;

  logic             step_meta;
  logic             step_sync;
  logic             db_level;
  logic [DB_W-1:0]  db_cnt;
  logic             step_tick;

  logic             tick_any;
  logic             pending;
  logic             overrun_q;
  logic [15:0]      gen_count_q;
  logic             gen_en_q;
  logic             seed_en_q;

  // A shift that empties the period (large speed) degrades to one tick per cycle.
  assign base_period = CNT_W'(CLK_HZ) >> bus.speed;
  assign period      = (base_period == '0) ? CNT_W'(1) : base_period;

  // Free-running period counter; >= lets a shorter period take effect at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tmr_cnt    <= '0;
      timer_tick <= 1'b0;
    end else if (!bus.run) begin
      tmr_cnt    <= '0;
      timer_tick <= 1'b0;
    end else if (tmr_cnt >= period - CNT_W'(1)) begin
      tmr_cnt    <= '0;
      timer_tick <= 1'b1;
    end else begin
      tmr_cnt    <= tmr_cnt + CNT_W'(1);
      timer_tick <= 1'b0;
    end
  end

  // Two-flop synchronizer for the raw step button.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      step_meta <= 1'b0;
      step_sync <= 1'b0;
    end else begin
      step_meta <= bus.step_btn;
      step_sync <= step_meta;
    end
  end

  // Debounce: the level follows only after DB_CYCLES consecutive differing samples;
  // the step tick is emitted on the rising transition of the debounced level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db_level  <= 1'b0;
      db_cnt    <= '0;
      step_tick <= 1'b0;
    end else if (step_sync == db_level) begin
      db_cnt    <= '0;
      step_tick <= 1'b0;
    end else if (db_cnt == DB_LAST) begin
      db_level  <= step_sync;
      db_cnt    <= '0;
      step_tick <= step_sync;
    end else begin
      db_cnt    <= db_cnt + DB_W'(1);
      step_tick <= 1'b0;
    end
  end

  assign tick_any = timer_tick | step_tick;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; seed requests pre-empt any pending generation.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.seed_req) begin
          state_n = SEED;
        end else if (pending) begin
          state_n = FRAME_SYNC ? WAIT_VBL : ISSUE;
        end
      end
      WAIT_VBL: begin
        if (bus.seed_req) begin
          state_n = SEED;
        end else if (bus.vblank_start) begin
          state_n = ISSUE;
        end
      end
      ISSUE:   state_n = IDLE;
      SEED:    state_n = HOLD;
      HOLD: begin
        if (!bus.seed_req) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes are registered off the next state so they coincide with ISSUE/SEED.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gen_en_q  <= 1'b0;
      seed_en_q <= 1'b0;
    end else begin
      gen_en_q  <= (state_n == ISSUE);
      seed_en_q <= (state_n == SEED);
    end
  end

  // Pending request, sticky overrun and generation counter.
  // A tick landing in the ISSUE cycle re-arms pending rather than counting as overrun.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending     <= 1'b0;
      overrun_q   <= 1'b0;
      gen_count_q <= '0;
    end else begin
      unique case (state)
        ISSUE: begin
          pending     <= tick_any;
          gen_count_q <= gen_count_q + 16'd1;
        end
        SEED: begin
          pending     <= 1'b0;
          overrun_q   <= 1'b0;
          gen_count_q <= '0;
        end
        default: begin
          if (tick_any) begin
            if (pending) begin
              overrun_q <= 1'b1;
            end else begin
              pending   <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.gen_en    = gen_en_q;
  assign bus.seed_en   = seed_en_q;
  assign bus.busy      = pending | (state != IDLE);
  assign bus.overrun   = overrun_q;
  assign bus.gen_count = gen_count_q;

endmodule
